// File: rtl/pricing_ctrl.sv
// Job sequencer for the backward-induction pricing datapath.
// Latches job parameters, sequences table build, time steps and readout, with watchdog and abort.

module pricing_ctrl #(
    parameter int N_STEPS     = 4000,
    parameter int READ_LAT    = 3,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        job_valid,
    output logic        job_ready,
    input  logic [63:0] job_p_up,
    input  logic [63:0] job_p_down,
    input  logic [63:0] job_llu,
    input  logic [63:0] job_lld,
    input  logic [63:0] job_kos,
    output logic [63:0] p_up,
    output logic [63:0] p_down,
    output logic [63:0] log_lambda_up,
    output logic [63:0] log_lambda_down,
    output logic [63:0] K_over_S,
    output logic        start_s1,
    input  logic        done_s1,
    input  logic        step_done,
    output logic        start_s2,
    input  logic [63:0] result_in,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [63:0] res_data,
    input  logic        abort,
    output logic        busy,
    output logic        timeout_err,
    output logic [15:0] step_cnt
);

    typedef enum logic [2:0] {
        IDLE, INIT, WAIT_S1, INDUCT, READOUT, CAPTURE, DONE, ERR
    } state_e;

    localparam int WD_W  = $clog2(TIMEOUT_CYC + 1);
    localparam int LAT_W = $clog2(READ_LAT + 1);
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYC - 1);
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(READ_LAT);

    state_e            state_q, state_d;
    logic [15:0]       step_cnt_q, step_cnt_d;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic [LAT_W-1:0]  lat_q, lat_d;
    logic [63:0]       p_up_q, p_up_d, p_down_q, p_down_d;
    logic [63:0]       llu_q, llu_d, lld_q, lld_d, kos_q, kos_d;
    logic [63:0]       res_data_q, res_data_d;
    logic              job_ready_q, job_ready_d;
    logic              start_s1_q, start_s1_d;
    logic              start_s2_q, start_s2_d;
    logic              res_valid_q, res_valid_d;
    logic              busy_q, busy_d;
    logic              timeout_err_q, timeout_err_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            step_cnt_q    <= '0;
            wd_q          <= '0;
            lat_q         <= '0;
            p_up_q        <= '0;
            p_down_q      <= '0;
            llu_q         <= '0;
            lld_q         <= '0;
            kos_q         <= '0;
            res_data_q    <= '0;
            job_ready_q   <= 1'b0;
            start_s1_q    <= 1'b0;
            start_s2_q    <= 1'b0;
            res_valid_q   <= 1'b0;
            busy_q        <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            step_cnt_q    <= step_cnt_d;
            wd_q          <= wd_d;
            lat_q         <= lat_d;
            p_up_q        <= p_up_d;
            p_down_q      <= p_down_d;
            llu_q         <= llu_d;
            lld_q         <= lld_d;
            kos_q         <= kos_d;
            res_data_q    <= res_data_d;
            job_ready_q   <= job_ready_d;
            start_s1_q    <= start_s1_d;
            start_s2_q    <= start_s2_d;
            res_valid_q   <= res_valid_d;
            busy_q        <= busy_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    // Abort overrides everything; the watchdog only advances while waiting on the datapath.
    always_comb begin
        state_d       = state_q;
        step_cnt_d    = step_cnt_q;
        wd_d          = wd_q;
        lat_d         = lat_q;
        p_up_d        = p_up_q;
        p_down_d      = p_down_q;
        llu_d         = llu_q;
        lld_d         = lld_q;
        kos_d         = kos_q;
        res_data_d    = res_data_q;
        timeout_err_d = timeout_err_q;
        if (abort) begin
            state_d       = IDLE;
            timeout_err_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (job_valid && job_ready_q) begin
                        state_d    = INIT;
                        step_cnt_d = '0;
                        p_up_d     = job_p_up;
                        p_down_d   = job_p_down;
                        llu_d      = job_llu;
                        lld_d      = job_lld;
                        kos_d      = job_kos;
                    end
                end
                INIT: begin
                    state_d = WAIT_S1;
                    wd_d    = '0;
                end
                WAIT_S1: begin
                    if (done_s1) begin
                        state_d = INDUCT;
                        wd_d    = '0;
                    end else if (wd_q == WD_LAST) begin
                        state_d       = ERR;
                        timeout_err_d = 1'b1;
                    end else begin
                        wd_d = wd_q + WD_W'(1);
                    end
                end
                INDUCT: begin
                    if (step_done) begin
                        wd_d = '0;
                        if (step_cnt_q != 16'hFFFF) begin
                            step_cnt_d = step_cnt_q + 16'd1;
                        end
                        if (step_cnt_d == 16'(N_STEPS)) begin
                            state_d = READOUT;
                        end
                    end else if (wd_q == WD_LAST) begin
                        state_d       = ERR;
                        timeout_err_d = 1'b1;
                    end else begin
                        wd_d = wd_q + WD_W'(1);
                    end
                end
                READOUT: begin
                    state_d = CAPTURE;
                    lat_d   = LAT_W'(1);
                end
                CAPTURE: begin
                    if (lat_q == LAT_LAST) begin
                        res_data_d = result_in;
                        state_d    = DONE;
                    end else begin
                        lat_d = lat_q + LAT_W'(1);
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        state_d = IDLE;
                    end
                end
                ERR: begin
                    state_d = ERR;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state so they line up with the registered state.
    always_comb begin
        job_ready_d = (state_d == IDLE);
        start_s1_d  = (state_d == INIT);
        start_s2_d  = (state_d == READOUT);
        res_valid_d = (state_d == DONE);
        busy_d      = (state_d != IDLE);
    end

    assign job_ready       = job_ready_q;
    assign start_s1        = start_s1_q;
    assign start_s2        = start_s2_q;
    assign res_valid       = res_valid_q;
    assign busy            = busy_q;
    assign timeout_err     = timeout_err_q;
    assign step_cnt        = step_cnt_q;
    assign res_data        = res_data_q;
    assign p_up            = p_up_q;
    assign p_down          = p_down_q;
    assign log_lambda_up   = llu_q;
    assign log_lambda_down = lld_q;
    assign K_over_S        = kos_q;

endmodule

// File: tb/tb_pricing_ctrl.sv
// Self-checking bench for pricing_ctrl: random job parameters and result words,
// expectations taken from the job-sequencing rules (step counts, latencies, timeouts).

module tb_pricing_ctrl;

    localparam int NS = 4;
    localparam int RL = 3;
    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        job_valid, job_ready;
    logic [63:0] job_p_up, job_p_down, job_llu, job_lld, job_kos;
    logic [63:0] p_up, p_down, log_lambda_up, log_lambda_down, K_over_S;
    logic        start_s1, done_s1, step_done, start_s2;
    logic [63:0] result_in, res_data;
    logic        res_valid, res_ready, abort, busy, timeout_err;
    logic [15:0] step_cnt;

    int testsRun = 0;
    int failCount = 0;
    logic [63:0] expP [5];

    pricing_ctrl #(.N_STEPS(NS), .READ_LAT(RL), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst),
        .job_valid(job_valid), .job_ready(job_ready),
        .job_p_up(job_p_up), .job_p_down(job_p_down), .job_llu(job_llu),
        .job_lld(job_lld), .job_kos(job_kos),
        .p_up(p_up), .p_down(p_down), .log_lambda_up(log_lambda_up),
        .log_lambda_down(log_lambda_down), .K_over_S(K_over_S),
        .start_s1(start_s1), .done_s1(done_s1), .step_done(step_done),
        .start_s2(start_s2), .result_in(result_in),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .abort(abort), .busy(busy), .timeout_err(timeout_err), .step_cnt(step_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "[TB] global timeout");
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic accept_job();
        for (int i = 0; i < 5; i++) expP[i] = {$urandom(), $urandom()};
        testsRun++;
        if (job_ready !== 1'b1) begin
            failCount++; $display("[TB] FAIL accept_ready: got %b expected 1", job_ready);
        end
        job_valid = 1'b1;
        job_p_up = expP[0]; job_p_down = expP[1]; job_llu = expP[2];
        job_lld = expP[3]; job_kos = expP[4];
        cyc();
        job_valid = 1'b0;
        job_p_up = {$urandom(), $urandom()}; job_kos = {$urandom(), $urandom()};
        testsRun++;
        if ({start_s1, busy, step_cnt} !== {1'b1, 1'b1, 16'd0}) begin
            failCount++;
            $display("[TB] FAIL init_outputs: start_s1/busy/step_cnt got %b/%b/%0d expected 1/1/0",
                     start_s1, busy, step_cnt);
        end
        testsRun++;
        if ({p_up, p_down, log_lambda_up, log_lambda_down, K_over_S} !==
            {expP[0], expP[1], expP[2], expP[3], expP[4]}) begin
            failCount++;
            $display("[TB] FAIL param_latch: p_up got %h expected %h, K_over_S got %h expected %h",
                     p_up, expP[0], K_over_S, expP[4]);
        end
        cyc();
        testsRun++;
        if (start_s1 !== 1'b0) begin
            failCount++; $display("[TB] FAIL start_s1_width: got %b expected 0", start_s1);
        end
    endtask

    task automatic finish_s1(input int gap);
        repeat (gap) cyc();
        done_s1 = 1'b1;
        cyc();
        done_s1 = 1'b0;
        testsRun++;
        if ({start_s2, timeout_err, busy, step_cnt} !== {1'b0, 1'b0, 1'b1, 16'd0}) begin
            failCount++;
            $display("[TB] FAIL enter_induct: start_s2/timeout_err/busy/step_cnt got %b/%b/%b/%0d expected 0/0/1/0",
                     start_s2, timeout_err, busy, step_cnt);
        end
    endtask

    task automatic do_steps(input int fromCnt, input int toCnt);
        for (int k = fromCnt + 1; k <= toCnt; k++) begin
            repeat ($urandom_range(0, 3)) cyc();
            step_done = 1'b1;
            cyc();
            step_done = 1'b0;
            testsRun++;
            if (step_cnt !== 16'(k) || start_s2 !== (k == NS)) begin
                failCount++;
                $display("[TB] FAIL step_%0d: step_cnt/start_s2 got %0d/%b expected %0d/%b",
                         k, step_cnt, start_s2, k, (k == NS));
            end
        end
    endtask

    // The datapath word is only meaningful on the READ_LAT-th cycle after start_s2.
    task automatic do_readout(input logic [63:0] base, input int hold);
        int k;
        bit got;
        bit stableOk;
        k = 0; got = 0; stableOk = 1;
        result_in = base + 64'd100;
        while (!got && k < 20) begin
            cyc();
            k++;
            if (res_valid === 1'b1) got = 1;
            else result_in = (k == RL) ? base : base + 64'(k) + 64'd100;
        end
        testsRun++;
        if (k !== RL + 1) begin
            failCount++; $display("[TB] FAIL res_valid_latency: got %0d expected %0d", k, RL + 1);
        end
        testsRun++;
        if (res_data !== base) begin
            failCount++; $display("[TB] FAIL res_data: got %h expected %h", res_data, base);
        end
        result_in = {$urandom(), $urandom()};
        for (int i = 0; i < hold; i++) begin
            cyc();
            if (res_valid !== 1'b1 || res_data !== base || job_ready !== 1'b0) stableOk = 0;
        end
        testsRun++;
        if (!stableOk) begin
            failCount++;
            $display("[TB] FAIL backpressure_hold: res_valid/job_ready got %b/%b res_data %h expected 1/0 %h",
                     res_valid, job_ready, res_data, base);
        end
        testsRun++;
        if ({p_up, K_over_S} !== {expP[0], expP[4]}) begin
            failCount++;
            $display("[TB] FAIL param_hold: p_up got %h expected %h", p_up, expP[0]);
        end
        res_ready = 1'b1;
        cyc();
        res_ready = 1'b0;
        testsRun++;
        if ({res_valid, job_ready, busy} !== 3'b010) begin
            failCount++;
            $display("[TB] FAIL handshake: res_valid/job_ready/busy got %b/%b/%b expected 0/1/0",
                     res_valid, job_ready, busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) cyc();
        testsRun++;
        if ({job_ready, busy, start_s1, start_s2, res_valid, timeout_err} !== 6'b0 ||
            step_cnt !== 16'd0 || res_data !== 64'd0 || p_up !== 64'd0 || K_over_S !== 64'd0) begin
            failCount++;
            $display("[TB] FAIL reset_state: ready/busy/s1/s2/rv/terr got %b%b%b%b%b%b step_cnt %0d expected all 0",
                     job_ready, busy, start_s1, start_s2, res_valid, timeout_err, step_cnt);
        end
        rst = 1'b0;
        cyc();
        testsRun++;
        if (job_ready !== 1'b1) begin
            failCount++; $display("[TB] FAIL reset_release_ready: got %b expected 1", job_ready);
        end
    endtask

    task automatic test_nominal();
        for (int j = 0; j < 3; j++) begin
            accept_job();
            finish_s1($urandom_range(0, 5));
            do_steps(0, NS);
            do_readout((j == 0) ? 64'h4010_0000_0000_0000 : {$urandom(), $urandom()},
                       $urandom_range(0, 3));
        end
    endtask

    task automatic test_stray();
        accept_job();
        step_done = 1'b1;
        cyc();
        step_done = 1'b0;
        testsRun++;
        if (step_cnt !== 16'd0 || start_s2 !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL stray_step_in_wait: step_cnt/start_s2 got %0d/%b expected 0/0", step_cnt, start_s2);
        end
        finish_s1(1);
        do_steps(0, 2);
        done_s1 = 1'b1;
        cyc();
        done_s1 = 1'b0;
        testsRun++;
        if (step_cnt !== 16'd2 || start_s2 !== 1'b0 || busy !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL stray_done_in_induct: step_cnt/start_s2/busy got %0d/%b/%b expected 2/0/1",
                     step_cnt, start_s2, busy);
        end
        do_steps(2, NS);
        do_readout({$urandom(), $urandom()}, 1);
    endtask

    task automatic test_back_to_back();
        accept_job();
        finish_s1(2);
        do_steps(0, NS);
        do_readout({$urandom(), $urandom()}, 10);
        accept_job();
        finish_s1(0);
        do_steps(0, NS);
        do_readout({$urandom(), $urandom()}, 0);
    endtask

    task automatic test_timeout();
        int k;
        for (int phase = 0; phase < 2; phase++) begin
            accept_job();
            if (phase == 1) begin
                finish_s1(1);
                do_steps(0, 1);
            end
            k = 0;
            while (timeout_err !== 1'b1 && k < 40) begin
                cyc();
                k++;
            end
            testsRun++;
            if (k !== TO) begin
                failCount++;
                $display("[TB] FAIL timeout_latency_phase%0d: got %0d cycles expected %0d", phase, k, TO);
            end
            repeat (5) cyc();
            testsRun++;
            if ({timeout_err, busy, job_ready} !== 3'b110) begin
                failCount++;
                $display("[TB] FAIL err_hold: timeout_err/busy/job_ready got %b/%b/%b expected 1/1/0",
                         timeout_err, busy, job_ready);
            end
            abort = 1'b1;
            cyc();
            abort = 1'b0;
            testsRun++;
            if ({timeout_err, busy, job_ready} !== 3'b001) begin
                failCount++;
                $display("[TB] FAIL err_abort: timeout_err/busy/job_ready got %b/%b/%b expected 0/0/1",
                         timeout_err, busy, job_ready);
            end
        end
    endtask

    task automatic test_abort();
        bit quiet;
        quiet = 1;
        job_valid = 1'b1;
        abort = 1'b1;
        cyc();
        job_valid = 1'b0;
        abort = 1'b0;
        testsRun++;
        if ({busy, start_s1, job_ready} !== 3'b001) begin
            failCount++;
            $display("[TB] FAIL abort_rejects_job: busy/start_s1/job_ready got %b/%b/%b expected 0/0/1",
                     busy, start_s1, job_ready);
        end
        accept_job();
        finish_s1(0);
        do_steps(0, NS);
        result_in = {$urandom(), $urandom()};
        cyc();
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        testsRun++;
        if ({res_valid, busy, job_ready} !== 3'b001) begin
            failCount++;
            $display("[TB] FAIL abort_capture: res_valid/busy/job_ready got %b/%b/%b expected 0/0/1",
                     res_valid, busy, job_ready);
        end
        repeat (6) begin
            cyc();
            if (res_valid !== 1'b0 || start_s2 !== 1'b0) quiet = 0;
        end
        testsRun++;
        if (!quiet) begin
            failCount++; $display("[TB] FAIL abort_quiet: res_valid/start_s2 got %b/%b expected 0/0", res_valid, start_s2);
        end
        accept_job();
        finish_s1(3);
        do_steps(0, NS);
        do_readout({$urandom(), $urandom()}, 2);
    endtask

    task automatic test_reset_midjob();
        bit quiet;
        quiet = 1;
        accept_job();
        finish_s1(0);
        do_steps(0, 2);
        rst = 1'b1;
        cyc();
        testsRun++;
        if ({job_ready, busy, start_s1, start_s2, res_valid, timeout_err} !== 6'b0 ||
            step_cnt !== 16'd0 || res_data !== 64'd0 || p_up !== 64'd0 ||
            p_down !== 64'd0 || log_lambda_up !== 64'd0 || log_lambda_down !== 64'd0 ||
            K_over_S !== 64'd0) begin
            failCount++;
            $display("[TB] FAIL reset_midjob: ready/busy/s1/s2/rv/terr got %b%b%b%b%b%b step_cnt %0d p_up %h expected all 0",
                     job_ready, busy, start_s1, start_s2, res_valid, timeout_err, step_cnt, p_up);
        end
        rst = 1'b0;
        cyc();
        repeat (3) begin
            step_done = 1'b1;
            cyc();
            step_done = 1'b0;
            cyc();
            if (step_cnt !== 16'd0 || busy !== 1'b0 || start_s2 !== 1'b0 ||
                res_valid !== 1'b0 || job_ready !== 1'b1) quiet = 0;
        end
        testsRun++;
        if (!quiet) begin
            failCount++;
            $display("[TB] FAIL post_reset_ignored: step_cnt/busy/job_ready got %0d/%b/%b expected 0/0/1",
                     step_cnt, busy, job_ready);
        end
    endtask

    initial begin
        rst = 1'b1; job_valid = 1'b0; done_s1 = 1'b0; step_done = 1'b0;
        res_ready = 1'b0; abort = 1'b0; result_in = '0;
        job_p_up = '0; job_p_down = '0; job_llu = '0; job_lld = '0; job_kos = '0;
        test_reset();
        test_nominal();
        test_stray();
        test_back_to_back();
        test_timeout();
        test_abort();
        test_reset_midjob();
        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
